// File: rtl/pdm_mic_ctrl_if.sv
// Stereo sample handoff from the PDM controller to the downstream audio path.
// The master drives samples and valid; the slave returns ready.
interface pdm_mic_ctrl_if;
  logic [15:0] lft_smp;
  logic [15:0] rght_smp;
  logic        smp_vld;
  logic        smp_rdy;

  modport master (
    output lft_smp,
    output rght_smp,
    output smp_vld,
    input  smp_rdy
  );

  modport slave (
    input  lft_smp,
    input  rght_smp,
    input  smp_vld,
    output smp_rdy
  );
endinterface

// File: rtl/pdm_mic_ctrl.sv
// Stereo PDM microphone controller: bit-clock generation, per-channel ones-count decimation,
// warm-up window discard and valid/ready sample delivery with sticky overrun.
module pdm_mic_ctrl #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned WIN_LOG2   = 8,
  parameter int unsigned WARMUP_WIN = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           pdm_data,
  output logic           pdm_clk,
  output logic           running,
  output logic           overrun,
  input  logic           ovr_clr,
  pdm_mic_ctrl_if.master smp
);
  localparam int unsigned DivW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q;
  logic                pdm_clk_q;
  logic [WIN_LOG2-1:0] win_q;
  logic [15:0]         lft_acc_q, rght_acc_q;
  logic [15:0]         lft_q, rght_q;
  logic [3:0]          wu_q;
  logic                vld_q, ovr_q;
  logic                active, tick, rise, fall, win_done, warm_last, deliver;

  // Dropping en takes effect on the same edge it is sampled, so the partial window dies at once.
  assign active    = (state_q != StIdle) && en;
  assign tick      = active && (div_q == DivW'(CLK_DIV - 1));
  assign rise      = tick && !pdm_clk_q;
  assign fall      = tick && pdm_clk_q;
  assign win_done  = fall && (&win_q);
  assign warm_last = (32'(wu_q) + 32'd1) >= WARMUP_WIN;
  assign deliver   = win_done && (state_q == StRun);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = (WARMUP_WIN == 0) ? StRun : StWarmup;
      end
      StWarmup: begin
        if (!en) state_d = StIdle;
        else if (win_done && warm_last) state_d = StRun;
      end
      StRun: begin
        if (!en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    running = 1'b0;
    if (state_q == StRun) running = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || !active) begin
      div_q      <= '0;
      pdm_clk_q  <= 1'b0;
      win_q      <= '0;
      lft_acc_q  <= '0;
      rght_acc_q <= '0;
      wu_q       <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + DivW'(1);
      if (tick) pdm_clk_q <= !pdm_clk_q;
      if (rise) rght_acc_q <= rght_acc_q + 16'(pdm_data);
      if (win_done) begin
        win_q      <= '0;
        lft_acc_q  <= '0;
        rght_acc_q <= '0;
      end else if (fall) begin
        win_q     <= win_q + WIN_LOG2'(1);
        lft_acc_q <= lft_acc_q + 16'(pdm_data);
      end
      if (win_done && (state_q == StWarmup)) wu_q <= wu_q + 4'd1;
    end
  end

  // The final left bit arrives on the completion edge itself, so it is folded in here.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_q  <= '0;
      rght_q <= '0;
      vld_q  <= 1'b0;
    end else if (!active) begin
      vld_q <= 1'b0;
    end else if (deliver) begin
      lft_q  <= lft_acc_q + 16'(pdm_data);
      rght_q <= rght_acc_q;
      vld_q  <= 1'b1;
    end else if (vld_q && smp.smp_rdy) begin
      vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (deliver && vld_q && !smp.smp_rdy) begin
      ovr_q <= 1'b1;
    end else if (ovr_clr) begin
      ovr_q <= 1'b0;
    end
  end

  assign pdm_clk      = pdm_clk_q;
  assign overrun      = ovr_q;
  assign smp.lft_smp  = lft_q;
  assign smp.rght_smp = rght_q;
  assign smp.smp_vld  = vld_q;
endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Directed and randomized bench for pdm_mic_ctrl against a window-level reference model.
module tb_pdm_mic_ctrl;
  localparam int CD = 2;
  localparam int WL = 3;
  localparam int WU = 1;
  localparam int W  = 1 << WL;
  localparam int P  = 2 * CD * W;  // clk edges per decimation window

  logic clk = 1'b0;
  logic rst, en, pdm_data, ovr_clr;
  logic pdm_clk, running, overrun;

  pdm_mic_ctrl_if bus ();

  pdm_mic_ctrl #(
    .CLK_DIV   (CD),
    .WIN_LOG2  (WL),
    .WARMUP_WIN(WU)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pdm_data(pdm_data),
    .pdm_clk (pdm_clk),
    .running (running),
    .overrun (overrun),
    .ovr_clr (ovr_clr),
    .smp     (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic        rec [4096];
  int          n;
  bit          enabled;
  logic        exp_vld, exp_ovr;
  logic [15:0] exp_lft, exp_rght;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clk edge: capture the inputs seen by the edge, advance the model, compare everything.
  task automatic step();
    logic d, r, c, e, rs;
    int   cur, l, rr;
    d  = pdm_data;
    r  = bus.smp_rdy;
    c  = ovr_clr;
    e  = en;
    rs = rst;
    @(posedge clk);
    #1;
    cur = 0;
    if (rs) begin
      enabled  = 1'b0;
      exp_vld  = 1'b0;
      exp_ovr  = 1'b0;
      exp_lft  = '0;
      exp_rght = '0;
    end else if (!e) begin
      enabled = 1'b0;
      exp_vld = 1'b0;
      if (c) exp_ovr = 1'b0;
    end else begin
      if (!enabled) begin
        enabled = 1'b1;
        n       = 0;
      end
      cur = n;
      rec[cur % 4096] = d;
      n++;
      // Bit events fall on every CD-th edge after enable: odd ones are rises (right), even falls.
      if (cur > 0 && (cur % P) == 0 && (cur / P) > WU) begin
        l  = 0;
        rr = 0;
        for (int t = cur - P + 1; t <= cur; t++) begin
          if ((t % CD) == 0) begin
            if (((t / CD) % 2) == 1) rr += int'(rec[t % 4096]);
            else l += int'(rec[t % 4096]);
          end
        end
        if (exp_vld && !r) exp_ovr = 1'b1;
        else if (c) exp_ovr = 1'b0;
        exp_lft  = 16'(l);
        exp_rght = 16'(rr);
        exp_vld  = 1'b1;
      end else begin
        if (exp_vld && r) exp_vld = 1'b0;
        if (c) exp_ovr = 1'b0;
      end
    end
    check("pdm_clk", 32'(pdm_clk), enabled ? 32'((cur / CD) % 2) : 32'd0);
    check("running", 32'(running), 32'(enabled && (cur >= P * WU)));
    check("smp_vld", 32'(bus.smp_vld), 32'(exp_vld));
    check("overrun", 32'(overrun), 32'(exp_ovr));
    check("lft_smp", 32'(bus.lft_smp), 32'(exp_lft));
    check("rght_smp", 32'(bus.rght_smp), 32'(exp_rght));
  endtask

  task automatic to_completion();
    for (int i = 0; i < P && (n % P) != 0; i++) begin
      pdm_data = 1'($urandom);
      step();
    end
  endtask

  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    pdm_data    = 1'b0;
    ovr_clr     = 1'b0;
    bus.smp_rdy = 1'b0;
    enabled     = 1'b0;
    n           = 0;
    exp_vld     = 1'b0;
    exp_ovr     = 1'b0;
    exp_lft     = '0;
    exp_rght    = '0;
    repeat (3) step();

    // All-ones input: first window discarded, then full-scale samples each window.
    rst         = 1'b0;
    en          = 1'b1;
    pdm_data    = 1'b1;
    bus.smp_rdy = 1'b1;
    for (int i = 0; i <= 3 * P; i++) step();
    check("t1_lft", 32'(bus.lft_smp), 32'(W));
    check("t1_rght", 32'(bus.rght_smp), 32'(W));

    // Data high only ahead of rise events: right full scale, left zero.
    for (int i = 0; i < 2 * P; i++) begin
      pdm_data = !pdm_clk;
      step();
    end
    check("t2_lft", 32'(bus.lft_smp), 32'd0);
    check("t2_rght", 32'(bus.rght_smp), 32'(W));

    // Consumer stalls across two completions.
    bus.smp_rdy = 1'b0;
    for (int i = 0; i < 2 * P; i++) begin
      pdm_data = 1'($urandom);
      step();
    end
    check("t3_ovr_set", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("t3_ovr_clr", 32'(overrun), 32'd0);
    to_completion();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("t3_set_wins", 32'(overrun), 32'd1);

    // Ready exactly on the completion edge with a sample pending.
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    to_completion();
    bus.smp_rdy = 1'b1;
    pdm_data    = 1'($urandom);
    step();
    check("t4_vld", 32'(bus.smp_vld), 32'd1);
    check("t4_ovr", 32'(overrun), 32'd0);

    // Random data and random consumer ready.
    for (int i = 0; i < 3 * P; i++) begin
      pdm_data    = 1'($urandom);
      bus.smp_rdy = 1'($urandom);
      ovr_clr     = ($urandom_range(0, 15) == 0);
      step();
    end
    ovr_clr     = 1'b0;
    bus.smp_rdy = 1'b1;

    // Enable dropped mid-window, then re-enabled.
    to_completion();
    for (int i = 0; i < P / 2; i++) begin
      pdm_data = 1'($urandom);
      step();
    end
    en = 1'b0;
    step();
    check("t5_pdm_clk", 32'(pdm_clk), 32'd0);
    check("t5_vld", 32'(bus.smp_vld), 32'd0);
    check("t5_running", 32'(running), 32'd0);
    repeat (3) step();
    en = 1'b1;
    for (int i = 0; i <= 3 * P; i++) begin
      pdm_data = 1'($urandom);
      step();
    end

    // Reset mid-window with en held high.
    for (int i = 0; i < P / 2; i++) begin
      pdm_data = 1'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    check("t6_rst_lft", 32'(bus.lft_smp), 32'd0);
    check("t6_rst_vld", 32'(bus.smp_vld), 32'd0);
    check("t6_rst_run", 32'(running), 32'd0);
    rst         = 1'b0;
    bus.smp_rdy = 1'b0;
    for (int i = 0; i < (WU + 1) * P; i++) begin
      pdm_data = 1'($urandom);
      step();
    end
    check("t6_pre_vld", 32'(bus.smp_vld), 32'd0);
    pdm_data = 1'($urandom);
    step();
    check("t6_first_vld", 32'(bus.smp_vld), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
